// File: rtl/traceback_walker.sv
// traceback_walker: walks the Needleman-Wunsch direction matrix from (N,M) back to (0,0),
// emitting one {A char, B char, move symbol} strobe per step to the Processing stage.
module traceback_walker #(
  parameter int N    = 5,
  parameter int M    = 5,
  parameter int AW_I = 3,
  parameter int AW_J = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [AW_I-1:0] dir_i,
  output logic [AW_J-1:0] dir_j,
  output logic            dir_rd_en,
  input  logic [2:0]      dir_data,
  output logic [AW_I-1:0] seqA_addr,
  input  logic [2:0]      seqA_data,
  output logic [AW_J-1:0] seqB_addr,
  input  logic [2:0]      seqB_data,
  output logic            en_traceB,
  output logic [2:0]      SeqA_i_t,
  output logic [2:0]      SeqB_j_t,
  output logic [2:0]      symbol,
  output logic            busy,
  output logic            done,
  output logic            error
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0]      state_q, state_d;
  logic [AW_I-1:0] i_q, i_d, ni;
  logic [AW_J-1:0] j_q, j_d, nj;
  logic [2:0]      a_q, a_d, b_q, b_d, sym_q, sym_d, code;
  logic            en_q, en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic            ip, jp, legal, rd;
  always_comb begin
    ip    = i_q != '0;
    jp    = j_q != '0;
    rd    = state_q == READ;
    // on the matrix edges the move is forced and the direction read is skipped
    code  = (ip && jp) ? dir_data : (!ip ? 3'b100 : 3'b010);
    legal = code inside {3'b001, 3'b010, 3'b100};
    ni    = (code[0] || code[1]) ? i_q - AW_I'(1) : i_q;
    nj    = (code[0] || code[2]) ? j_q - AW_J'(1) : j_q;
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    a_d     = a_q;
    b_d     = b_q;
    sym_d   = sym_q;
    en_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        i_d     = AW_I'(N);
        j_d     = AW_J'(M);
        err_d   = 1'b0;
        busy_d  = 1'b1;
      end
      READ: state_d = EMIT;
      EMIT: if (!legal) begin
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        a_d     = ip ? seqA_data : 3'b000;
        b_d     = jp ? seqB_data : 3'b000;
        sym_d   = code;
        en_d    = 1'b1;
        i_d     = ni;
        j_d     = nj;
        state_d = (ni == '0 && nj == '0) ? DONE : READ;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sym_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sym_q   <= sym_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign dir_i     = i_q;
  assign dir_j     = j_q;
  assign dir_rd_en = rd && ip && jp;
  assign seqA_addr = rd ? i_q - AW_I'(1) : '0;
  assign seqB_addr = rd ? j_q - AW_J'(1) : '0;
  assign en_traceB = en_q;
  assign SeqA_i_t  = a_q;
  assign SeqB_j_t  = b_q;
  assign symbol    = sym_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = err_q;
endmodule
